median_driver: RTL and testbench

Initiator side of the MEDIAN window protocol. Accepts a pixel stream on a valid/ready interface and groups it into 9-pixel windows. Each full window is replayed to MEDIAN as one contiguous burst with DSI high for exactly 9 cycles. The block then waits for DSO, captures DO and presents the median downstream on a second valid/ready interface; it sits between the pixel source and the downstream result consumer.

---
 rtl/median_driver.sv | 80 ++++++++
 tb/tb_median_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/median_driver.sv
// median_driver: groups a pixel stream into NPIX-pixel windows, bursts each to MEDIAN and returns the median downstream
// Ports:
//   CLK, nRST                      clock, synchronous active-low reset
//   IN_DATA, IN_VALID, IN_READY    upstream pixel stream
//   MED_DI, MED_DSI                registered window burst to MEDIAN
//   MED_DO, MED_DSO                median result pulse from MEDIAN
//   OUT_DATA, OUT_VALID, OUT_READY registered result to the downstream consumer
//   ERR                            sticky timeout / stray-DSO flag
module median_driver #(
  parameter int WIDTH   = 8,
  parameter int NPIX    = 9,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] MED_DI,
  output logic             MED_DSI,
  input  logic [WIDTH-1:0] MED_DO,
  input  logic             MED_DSO,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             ERR
);
  localparam int FW = $clog2(NPIX + 1);
  localparam int SW = $clog2(NPIX);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FULL  = FW'(NPIX);
  localparam logic [SW-1:0] LAST  = SW'(NPIX - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] pix [NPIX];
  logic [FW-1:0]    fill_cnt;
  logic [SW-1:0]    send_idx;
  logic [TW-1:0]    wait_cnt;
  logic             take, start, last, done, tout;
  assign IN_READY = nRST && state != SEND && fill_cnt != FULL;
  assign take     = IN_VALID && IN_READY;
  // a burst only starts when the result register is free (or freeing this edge)
  assign start    = state == IDLE && fill_cnt == FULL && (!OUT_VALID || OUT_READY);
  assign last     = state == SEND && send_idx == LAST;
  assign done     = state == WAIT && MED_DSO;
  // DSO in the final wait cycle still wins over the timeout
  assign tout     = state == WAIT && !MED_DSO && wait_cnt == TLAST;
  always_comb begin
    state_n = state;
    state_n = start ? SEND : last ? WAIT : (done || tout) ? IDLE : state;
  end
  always_ff @(posedge CLK) begin
    if (take) pix[fill_cnt] <= IN_DATA;
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      send_idx  <= '0;
      wait_cnt  <= '0;
      MED_DSI   <= 1'b0;
      MED_DI    <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_n;
      fill_cnt  <= last ? '0 : fill_cnt + FW'(take);
      send_idx  <= (state == SEND && !last) ? send_idx + 1'b1 : '0;
      wait_cnt  <= (state == WAIT && state_n == WAIT) ? wait_cnt + 1'b1 : '0;
      // DI/DSI are registered one pixel ahead so the burst is gap-free
      MED_DSI   <= start || (state == SEND && !last);
      MED_DI    <= start ? pix[0] : (state == SEND && !last) ? pix[send_idx + 1'b1] : MED_DI;
      OUT_DATA  <= done ? MED_DO : OUT_DATA;
      OUT_VALID <= done || (OUT_VALID && !OUT_READY);
      ERR       <= ERR || tout || (MED_DSO && state != WAIT);
    end
  end
endmodule

// File: tb/tb_median_driver.sv
// tb_median_driver: scoreboard bench for median_driver with a behavioural MEDIAN model
module tb_median_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] med_do = '0;
  logic       med_dso = 1'b0;
  logic       IN_READY, MED_DSI, OUT_VALID, ERR;
  logic [7:0] MED_DI, OUT_DATA;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] pix_q[$];
  logic [7:0] med_q[$];
  logic [7:0] win [9];
  int         wn = 0;
  logic [7:0] mwin [9];
  int         mcnt = 0;
  int         mlat = 0;
  int         lat = 2;
  int         run = 0;
  bit         no_dso = 1'b0;
  bit         rand_ordy = 1'b0;
  logic [7:0] last_out = '0;
  int         n_out = 0;

  median_driver #(.WIDTH(8), .NPIX(9), .TIMEOUT(16)) dut (
    .CLK(clk), .nRST(rst_n),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(IN_READY),
    .MED_DI(MED_DI), .MED_DSI(MED_DSI), .MED_DO(med_do), .MED_DSO(med_dso),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(out_ready),
    .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] med9(input logic [7:0] w [9]);
    logic [7:0] a [9];
    logic [7:0] t;
    a = w;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[4];
  endfunction

  // stimulus/result scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && IN_READY) begin
        pix_q.push_back(in_data);
        win[wn] = in_data;
        wn++;
        if (wn == 9) begin med_q.push_back(med9(win)); wn = 0; end
      end
      if (OUT_VALID && out_ready) begin
        if (med_q.size() == 0) chk("out_unexpected", med_q.size(), 1);
        else chk("out_data", OUT_DATA, med_q.pop_front());
        last_out = OUT_DATA;
        n_out++;
      end
    end
  end

  // behavioural MEDIAN: collects a DSI burst, pulses DSO after lat cycles
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      mcnt = 0; mlat = 0; run = 0; med_dso = 1'b0;
    end else begin
      med_dso = 1'b0;
      if (mlat != 0) begin
        mlat--;
        if (mlat == 0 && !no_dso) begin med_dso = 1'b1; med_do = med9(mwin); end
      end
      if (MED_DSI) begin
        run++;
        e = pix_q.size() != 0 ? pix_q.pop_front() : 8'hxx;
        chk("di_order", MED_DI, e);
        chk("in_ready_in_send", IN_READY, 0);
        mwin[mcnt] = MED_DI;
        mcnt++;
        if (mcnt == 9) begin mcnt = 0; mlat = lat; end
      end else if (run != 0) begin
        chk("dsi_len", run, 9);
        run = 0;
      end
    end
  end

  always @(posedge clk) if (rand_ordy) begin
    #1 out_ready = $urandom_range(3) != 0;
    lat = $urandom_range(6, 1);
  end

  task automatic push(input logic [7:0] d, input int idle);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (idle != 0 && $urandom_range(99) < idle) begin in_valid = 1'b0; @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && n < 2000) begin @(negedge clk); ok = IN_READY; @(posedge clk); #1; n++; end
    if (!ok) chk("accept_timeout", n, 0);
    in_valid = 1'b0;
  endtask

  task automatic push_win(input logic [7:0] w [9], input int idle);
    for (int i = 0; i < 9; i++) push(w[i], idle);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (med_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_drain"}, med_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] wa [9] = '{5, 3, 9, 1, 7, 2, 8, 4, 6};
    logic [7:0] wb [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    logic [7:0] wr [9];
    int         n, n0;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_dsi", MED_DSI, 0);
    chk("rst_di", MED_DI, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_err", ERR, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // 1: two windows, gap-free, OUT_READY=1
    for (int i = 0; i < 9; i++) push(wa[i], 0);
    @(negedge clk);
    chk("t1_full_ready", IN_READY, 0);
    chk("t1_dsi_pre", MED_DSI, 0);
    @(negedge clk);
    chk("t1_dsi_start", MED_DSI, 1);
    chk("t1_di0", MED_DI, 5);
    @(posedge clk); #1;
    push_win(wb, 0);
    drain("t1");
    chk("t1_nout", n_out, 2);
    chk("t1_last", last_out, 5);
    chk("t1_err", ERR, 0);
    // 2: random IN_VALID gaps
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 9; i++) wr[i] = 8'($urandom_range(255));
      push_win(wr, 50);
    end
    drain("t2");
    chk("t2_nout", n_out, 7);
    // 3: downstream stall after the first result
    out_ready = 1'b0;
    push_win(wa, 0);
    push_win(wb, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("t3_dsi_held", MED_DSI, 0);
      chk("t3_ready_full", IN_READY, 0);
      chk("t3_out_valid", OUT_VALID, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_send_next", MED_DSI, 1);
    drain("t3");
    chk("t3_last", last_out, 5);
    chk("t3_nout", n_out, 9);
    // 4: MEDIAN never answers
    no_dso = 1'b1;
    push_win(wa, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!MED_DSI && n < 100);
    do begin @(negedge clk); n++; end while (MED_DSI && n < 200);
    chk("t4_burst_end", MED_DSI, 0);
    repeat (15) @(negedge clk);
    chk("t4_err_early", ERR, 0);
    @(negedge clk);
    chk("t4_err", ERR, 1);
    chk("t4_no_out", OUT_VALID, 0);
    if (med_q.size() != 0) void'(med_q.pop_front());
    no_dso = 1'b0;
    @(posedge clk); #1;
    push_win(wb, 0);
    drain("t4");
    chk("t4_nout", n_out, 10);
    chk("t4_last", last_out, 5);
    // 5: reset during the 4th SEND cycle
    push_win(wb, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!MED_DSI && n < 100);
    chk("t5_burst", MED_DSI, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    pix_q.delete();
    med_q.delete();
    wn = 0;
    @(negedge clk);
    chk("t5_dsi", MED_DSI, 0);
    chk("t5_out_valid", OUT_VALID, 0);
    chk("t5_err", ERR, 0);
    @(posedge clk); #1;
    push_win(wa, 0);
    drain("t5");
    chk("t5_nout", n_out, 11);
    chk("t5_last", last_out, 5);
    // 6: random windows with random handshakes
    n0 = n_out;
    rand_ordy = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 9; i++) wr[i] = 8'($urandom_range(255));
      push_win(wr, 30);
    end
    drain("t6a");
    rand_ordy = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain("t6");
    chk("t6_nout", n_out - n0, 1000);
    chk("t6_err", ERR, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
